fetch_sequencer: RTL and testbench

- Instruction fetch and sequencing stage directly upstream of the controller's opcode decoder.
- Fetches one opcode per instruction from program memory into an instruction register and presents it to the decoder.
- Reads the decoder's 2-bit state_control back and steps a FETCH/DECODE/MEM/EXEC state machine.
- Emits the strobes that gate register-bank writeback and data-memory access.

---
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_sequencer.sv | 53 +++++
 tb/tb_fetch_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: program-memory and decoder handshake bundle for the fetch stage
interface fetch_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_rd;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_data;
    logic            imem_valid;
    logic [1:0]      state_control;
    logic [7:0]      opcode;
    logic            exec_en;
    logic            mem_en;

    modport master (
        output imem_rd, imem_addr, opcode, exec_en, mem_en,
        input  imem_data, imem_valid, state_control
    );

    modport slave (
        input  imem_rd, imem_addr, opcode, exec_en, mem_en,
        output imem_data, imem_valid, state_control
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: opcode fetch into the instruction register and FETCH/DECODE/MEM/EXEC sequencing
module fetch_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    fetch_sequencer_if.master bus,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic [CNT_W-1:0]  retired
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, EXEC} state_t;

    state_t     state;
    logic [7:0] opcode;

    // Strobes are pure state decodes so they drop the instant reset forces IDLE.
    assign bus.imem_rd   = state == FETCH;
    assign bus.mem_en    = state == MEM;
    assign bus.exec_en   = state == EXEC;
    assign bus.imem_addr = pc;
    assign bus.opcode    = opcode;
    assign busy          = state != IDLE;

    // Sequencer: halt (10) returns to IDLE without retiring; reserved 11 runs as plain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            opcode  <= 8'h00;
            retired <= '0;
        end else begin
            case (state)
                IDLE:   state <= start ? FETCH : IDLE;
                FETCH:  if (bus.imem_valid) begin
                            opcode <= bus.imem_data;
                            pc     <= pc + 1'b1;
                            state  <= DECODE;
                        end
                DECODE: state <= bus.state_control == 2'b10 ? IDLE :
                                 bus.state_control == 2'b01 ? MEM : EXEC;
                MEM:    state <= EXEC;
                EXEC:   begin
                            retired <= retired + 1'b1;
                            state   <= FETCH;
                        end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized instruction stream checked cycle by cycle against an instruction-level model
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pc;
    logic        busy;
    logic [15:0] retired;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  m_pc = 8'h00;
    logic [7:0]  m_op = 8'h00;
    logic [15:0] m_ret = 16'h0;

    fetch_sequencer_if #(.PC_W(8)) bus ();

    fetch_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .pc(pc), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.imem_valid = 1'b0;
        #1;
        m_pc = 8'h00;
        m_op = 8'h00;
        m_ret = 16'h0;
        chk("rst_imem_rd", 32'(bus.imem_rd), 0);
        chk("rst_strobes", 32'({bus.exec_en, bus.mem_en}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_opcode", 32'(bus.opcode), 0);
        chk("rst_retired", 32'(retired), 0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            bus.imem_valid = 1'($urandom);
            bus.imem_data = 8'($urandom);
            bus.state_control = 2'($urandom);
            step();
            chk("idle_busy", 32'(busy), 0);
            chk("idle_imem_rd", 32'(bus.imem_rd), 0);
            chk("idle_strobes", 32'({bus.exec_en, bus.mem_en}), 0);
            chk("idle_pc", 32'(pc), 32'(m_pc));
            chk("idle_opcode", 32'(bus.opcode), 32'(m_op));
            chk("idle_retired", 32'(retired), 32'(m_ret));
        end
        bus.imem_valid = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        bus.imem_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    // One instruction from its first FETCH cycle; w wait cycles, sc decoder verdict,
    // rst_at 1 = reset on the last FETCH cycle, 2 = reset during MEM.
    task automatic run_instr(input logic [7:0] op, input int w, input logic [1:0] sc, input int rst_at);
        for (int i = 0; i <= w; i++) begin
            chk("fetch_imem_rd", 32'(bus.imem_rd), 1);
            chk("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
            chk("fetch_busy", 32'(busy), 1);
            chk("fetch_strobes", 32'({bus.exec_en, bus.mem_en}), 0);
            chk("fetch_opcode", 32'(bus.opcode), 32'(m_op));
            chk("fetch_retired", 32'(retired), 32'(m_ret));
            if (rst_at == 1 && i == w) begin
                do_reset();
                return;
            end
            bus.imem_valid = (i == w);
            bus.imem_data = (i == w) ? op : 8'($urandom);
            bus.state_control = 2'($urandom);
            start = 1'($urandom);
            step();
        end
        m_pc = m_pc + 8'd1;
        m_op = op;
        chk("dec_imem_rd", 32'(bus.imem_rd), 0);
        chk("dec_pc", 32'(pc), 32'(m_pc));
        chk("dec_opcode", 32'(bus.opcode), 32'(m_op));
        chk("dec_strobes", 32'({bus.exec_en, bus.mem_en}), 0);
        chk("dec_busy", 32'(busy), 1);
        bus.state_control = sc;
        bus.imem_valid = 1'($urandom);
        bus.imem_data = 8'($urandom);
        start = 1'($urandom);
        step();
        bus.state_control = 2'($urandom);
        if (sc == 2'b10) begin
            start = 1'b0;
            bus.imem_valid = 1'b0;
            chk("halt_busy", 32'(busy), 0);
            chk("halt_strobes", 32'({bus.exec_en, bus.mem_en}), 0);
            chk("halt_retired", 32'(retired), 32'(m_ret));
            chk("halt_opcode", 32'(bus.opcode), 32'(m_op));
            return;
        end
        if (sc == 2'b01) begin
            chk("mem_strobes", 32'({bus.exec_en, bus.mem_en}), 32'b01);
            chk("mem_imem_rd", 32'(bus.imem_rd), 0);
            chk("mem_opcode", 32'(bus.opcode), 32'(m_op));
            if (rst_at == 2) begin
                do_reset();
                return;
            end
            step();
        end
        chk("exec_strobes", 32'({bus.exec_en, bus.mem_en}), 32'b10);
        chk("exec_opcode", 32'(bus.opcode), 32'(m_op));
        chk("exec_retired", 32'(retired), 32'(m_ret));
        m_ret = m_ret + 16'd1;
        step();
        start = 1'b0;
        bus.imem_valid = 1'b0;
    endtask

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_data = 8'h00;
        bus.state_control = 2'b00;
        step();
        chk("init_busy", 32'(busy), 0);
        chk("init_imem_rd", 32'(bus.imem_rd), 0);
        chk("init_pc", 32'(pc), 0);
        chk("init_opcode", 32'(bus.opcode), 0);
        chk("init_retired", 32'(retired), 0);
        rst = 1'b0;
        idle(3);
        launch();
        run_instr(8'h03, 0, 2'b00, 0);
        chk("first_pc", 32'(pc), 1);
        chk("first_retired", 32'(retired), 1);
        run_instr(8'($urandom), 2, 2'b01, 0);
        run_instr(8'($urandom), 0, 2'b10, 0);
        idle(2);
        launch();
        for (int k = 0; k < 4; k++) run_instr(8'($urandom), 0, 2'($urandom_range(0, 1) * 3), 0);
        run_instr(8'($urandom), 1, 2'b10, 0);
        launch();
        for (int k = 0; k < 60; k++) begin
            logic [1:0] sc;
            sc = 2'($urandom);
            run_instr(8'($urandom), $urandom_range(0, 3), sc, 0);
            if (sc == 2'b10) begin
                idle($urandom_range(0, 2));
                launch();
            end
        end
        chk("rand_retired", 32'(retired), 32'(m_ret));
        run_instr(8'($urandom), 1, 2'b00, 1);
        idle(2);
        launch();
        run_instr(8'($urandom), 0, 2'b01, 2);
        idle(2);
        launch();
        for (int k = 0; k < 255; k++) run_instr(8'($urandom), 0, 2'b00, 0);
        chk("pc_ff", 32'(pc), 32'hff);
        run_instr(8'h5a, 0, 2'b00, 0);
        chk("pc_wrap", 32'(pc), 0);
        chk("wrap_addr", 32'(bus.imem_addr), 0);
        chk("wrap_retired", 32'(retired), 256);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
